// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 raster geometry, sync polarities and counter width
package vga_pkg;
   localparam int CNT_W     = 11;
   localparam int H_VISIBLE = 800;
   localparam int H_FP      = 40;
   localparam int H_SYNC    = 128;
   localparam int H_BP      = 88;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_VISIBLE = 600;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 4;
   localparam int V_BP      = 23;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam bit HSYNC_POL = 1'b1;
   localparam bit VSYNC_POL = 1'b1;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-timing bus from the raster generator to the drawing pipeline
interface vga_timing_gen_if;
   import vga_pkg::*;
   cnt_t        hcount_out;
   logic        hsync_out;
   logic        hblnk_out;
   cnt_t        vcount_out;
   logic        vsync_out;
   logic        vblnk_out;
   logic        frame_start;
   logic [15:0] frame_cnt;
   modport master (output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, frame_start, frame_cnt);
   modport slave  (input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, frame_start, frame_cnt);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping axis counter with terminal-count strobe and registered sync/blank decode
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE,
   parameter int FP      = H_FP,
   parameter int SYNC    = H_SYNC,
   parameter int BP      = H_BP,
   parameter bit POL     = 1'b1
)(
   input  logic pclk,
   input  logic rst_n,
   input  logic i_adv,
   output cnt_t o_count,
   output logic o_sync,
   output logic o_blnk,
   output logic o_wrap
);
   localparam int   TOTAL     = VISIBLE + FP + SYNC + BP;
   localparam cnt_t L_LAST    = CNT_W'(TOTAL - 1);
   localparam cnt_t L_VIS     = CNT_W'(VISIBLE);
   localparam cnt_t L_SYNC_LO = CNT_W'(VISIBLE + FP);
   localparam cnt_t L_SYNC_HI = CNT_W'(VISIBLE + FP + SYNC);
   if (TOTAL > (1 << CNT_W)) begin : g_too_big
      $error("vga_axis_counter: total period exceeds counter range");
   end
   cnt_t r_count;
   cnt_t w_next;
   assign o_wrap  = i_adv && (r_count == L_LAST);
   assign w_next  = o_wrap ? '0 : i_adv ? r_count + CNT_W'(1) : r_count;
   assign o_count = r_count;
   // count and decode sync/blank from the next value so every field lines up with the count
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         o_blnk  <= 1'b0;
         o_sync  <= ~POL;
      end else begin
         r_count <= w_next;
         o_blnk  <= w_next >= L_VIS;
         o_sync  <= (w_next >= L_SYNC_LO && w_next < L_SYNC_HI) ? POL : ~POL;
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing source; VGA_TIMING_FRAME_CNT_EN enables the frame counter
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FP      = vga_pkg::H_FP,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BP      = vga_pkg::H_BP,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FP      = vga_pkg::V_FP,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BP      = vga_pkg::V_BP,
   parameter bit HSYNC_POL = vga_pkg::HSYNC_POL,
   parameter bit VSYNC_POL = vga_pkg::VSYNC_POL
)(
   input logic               pclk,
   input logic               rst_n,
   vga_timing_gen_if.master  vga
);
   logic w_h_wrap;
   logic w_v_wrap;
   logic r_frame_start;
   vga_axis_counter #(.VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)) u_h (
      .pclk(pclk), .rst_n(rst_n), .i_adv(1'b1),
      .o_count(vga.hcount_out), .o_sync(vga.hsync_out), .o_blnk(vga.hblnk_out), .o_wrap(w_h_wrap)
   );
   vga_axis_counter #(.VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)) u_v (
      .pclk(pclk), .rst_n(rst_n), .i_adv(w_h_wrap),
      .o_count(vga.vcount_out), .o_sync(vga.vsync_out), .o_blnk(vga.vblnk_out), .o_wrap(w_v_wrap)
   );
   // the vertical wrap is the only way into (0,0), so reset itself never raises frame_start
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) r_frame_start <= 1'b0;
      else        r_frame_start <= w_v_wrap;
   end
   assign vga.frame_start = r_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;
   // counts on the same edge that raises frame_start; wraps naturally at 16 bits
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n)        r_frame_cnt <= '0;
      else if (w_v_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
   end
   assign vga.frame_cnt = r_frame_cnt;
`else
   assign vga.frame_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed check of a 16x10 raster, active-high (dut_a) and active-low (dut_b) syncs
module tb_vga_timing_gen;
   logic pclk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam int FC_EN = 1;
`else
   localparam int FC_EN = 0;
`endif
   always #5 pclk = ~pclk;
   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();
   vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_a (.pclk(pclk), .rst_n(rst_n), .vga(if_a.master));
   vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_b (.pclk(pclk), .rst_n(rst_n), .vga(if_b.master));
   typedef struct {
      int cyc; int h; int v; bit hs; bit hb; bit vs; bit vb; bit fs;
   } vec_t;
   vec_t vec [18];
   function automatic logic [26:0] pack_a();
      return {if_a.hcount_out, if_a.vcount_out, if_a.hsync_out, if_a.hblnk_out, if_a.vsync_out, if_a.vblnk_out, if_a.frame_start};
   endfunction
   function automatic logic [26:0] pack_b();
      return {if_b.hcount_out, if_b.vcount_out, if_b.hsync_out, if_b.hblnk_out, if_b.vsync_out, if_b.vblnk_out, if_b.frame_start};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic check_reset(input string name);
      check({name, "_a"}, {5'b0, pack_a()}, {5'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      check({name, "_b"}, {5'b0, pack_b()}, {5'b0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      check({name, "_fc"}, {16'b0, if_a.frame_cnt}, 32'd0);
   endtask
   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge pclk);
         cyc++;
      end
      #1;
   endtask
   initial begin
      int fs_seen;
      int last_fs;
      vec[0]  = '{1,   1,  0, 0, 0, 0, 0, 0};
      vec[1]  = '{7,   7,  0, 0, 0, 0, 0, 0};
      vec[2]  = '{8,   8,  0, 0, 1, 0, 0, 0};
      vec[3]  = '{9,   9,  0, 0, 1, 0, 0, 0};
      vec[4]  = '{10,  10, 0, 1, 1, 0, 0, 0};
      vec[5]  = '{12,  12, 0, 1, 1, 0, 0, 0};
      vec[6]  = '{13,  13, 0, 0, 1, 0, 0, 0};
      vec[7]  = '{15,  15, 0, 0, 1, 0, 0, 0};
      vec[8]  = '{16,  0,  1, 0, 0, 0, 0, 0};
      vec[9]  = '{96,  0,  6, 0, 0, 0, 1, 0};
      vec[10] = '{106, 10, 6, 1, 1, 0, 1, 0};
      vec[11] = '{112, 0,  7, 0, 0, 1, 1, 0};
      vec[12] = '{143, 15, 8, 0, 1, 1, 1, 0};
      vec[13] = '{144, 0,  9, 0, 0, 0, 1, 0};
      vec[14] = '{159, 15, 9, 0, 1, 0, 1, 0};
      vec[15] = '{160, 0,  0, 0, 0, 0, 0, 1};
      vec[16] = '{161, 1,  0, 0, 0, 0, 0, 0};
      vec[17] = '{320, 0,  0, 0, 0, 0, 0, 1};
      repeat (10) @(posedge pclk);
      #1;
      check_reset("reset");
      @(negedge pclk);
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 18; i++) begin
         step_to(vec[i].cyc);
         check($sformatf("vec%0d_a", i), {5'b0, pack_a()},
               {5'b0, 11'(vec[i].h), 11'(vec[i].v), vec[i].hs, vec[i].hb, vec[i].vs, vec[i].vb, vec[i].fs});
         check($sformatf("vec%0d_b", i), {5'b0, pack_b()},
               {5'b0, 11'(vec[i].h), 11'(vec[i].v), ~vec[i].hs, vec[i].hb, ~vec[i].vs, vec[i].vb, vec[i].fs});
      end
      fs_seen = 0;
      last_fs = 320;
      for (int i = 0; i < 480; i++) begin
         step_to(cyc + 1);
         if (if_a.frame_start) begin
            fs_seen++;
            check("fs_period", cyc - last_fs, 160);
            last_fs = cyc;
         end
      end
      check("fs_count", fs_seen, 3);
      check("frame_cnt5", {16'b0, if_a.frame_cnt}, FC_EN ? 32'd5 : 32'd0);
      step_to(853);
      check("pre_rst_pos", {21'b0, if_a.hcount_out}, 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      cyc = 0;
      fs_seen = 0;
      for (int i = 0; i < 159; i++) begin
         step_to(cyc + 1);
         if (if_a.frame_start || if_b.frame_start) fs_seen++;
      end
      check("no_early_fs", fs_seen, 0);
      step_to(160);
      check("fs_after_rst", {31'b0, if_a.frame_start}, 32'd1);
      check("frame_cnt1", {16'b0, if_a.frame_cnt}, FC_EN ? 32'd1 : 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
